// File: rtl/cmac_engine.sv
// cmac_engine -- AES-CMAC (RFC 4493) tag engine built around an iterative AES-128 core.
//
// Ports (cmac_engine):
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   key_valid/key/key_ready     128-bit key load handshake
//   blk_valid/blk_data/blk_last/blk_len/blk_ready
//                               message block handshake, byte 0 = blk_data[127:120],
//                               blk_len (clamped to 16) only meaningful with blk_last
//   tag_valid/tag/tag_ready     tag output handshake, tag = top TAG_BITS of the MAC
//   busy                        high except in IDLE and WAIT_BLK
// Parameters: TAG_BITS (32..128, multiple of 8), BLK_FIFO (0/1 skid entry on block input).
// Optional build macro CMAC_VERIFY_EN: adds ref_tag input (taken with the last block)
// and tag_match output (valid with tag_valid).
//
// aes128_core: ld loads din/key, done pulses one cycle when dout holds the ciphertext.
// One round per cycle, S-box computed as GF(2^8) inverse plus affine map.

module aes128_core (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);
  logic [127:0] st, rk, rk_nx, st_nx;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         run;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, v;
    sq = x;
    v  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t0, t1, t2, t3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      // ShiftRows: row r of column c comes from column (c+r) mod 4
      t0 = b[4*c];
      t1 = b[4*((c+1)%4)+1];
      t2 = b[4*((c+2)%4)+2];
      t3 = b[4*((c+3)%4)+3];
      if (last) r[127-32*c -: 32] = {t0, t1, t2, t3};
      else      r[127-32*c -: 32] = {xt(t0) ^ xt(t1) ^ t1 ^ t2 ^ t3,
                                     t0 ^ xt(t1) ^ xt(t2) ^ t2 ^ t3,
                                     t0 ^ t1 ^ xt(t2) ^ xt(t3) ^ t3,
                                     xt(t0) ^ t0 ^ t1 ^ t2 ^ xt(t3)};
    end
    return r ^ k;
  endfunction

  assign rk_nx = kexp(rk, rcon);
  assign st_nx = round_fn(st, rk_nx, rnd == 4'd10);
  assign dout  = st;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st <= '0; rk <= '0; rcon <= '0; rnd <= '0; run <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        st   <= din ^ key;
        rk   <= key;
        rcon <= 8'h01;
        rnd  <= 4'd1;
        run  <= 1'b1;
      end else if (run) begin
        st   <= st_nx;
        rk   <= rk_nx;
        rcon <= xt(rcon);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

module cmac_engine #(
  parameter int TAG_BITS = 128,
  parameter int BLK_FIFO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [127:0]        key,
  output logic                key_ready,
  input  logic                blk_valid,
  input  logic [127:0]        blk_data,
  input  logic                blk_last,
  input  logic [4:0]          blk_len,
  output logic                blk_ready,
  output logic                tag_valid,
  output logic [TAG_BITS-1:0] tag,
  input  logic                tag_ready,
  output logic                busy
`ifdef CMAC_VERIFY_EN
  ,
  input  logic [TAG_BITS-1:0] ref_tag,
  output logic                tag_match
`endif
);
  typedef enum logic [2:0] {IDLE, SUBKEY, WAIT_BLK, RUN, LAST, TAG_OUT} state_t;
  state_t state, state_nx;

  logic [127:0] key_r, k1, k2, x, aes_din, aes_dout;
  logic [127:0] skid_data;
  logic [4:0]   skid_len;
  logic         skid_vld, skid_last;
  logic         aes_ld, aes_done, key_loaded;
  logic         key_go, blk_go, skid_go, skid_load;

  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  // Block as fed to the chain: unchanged unless last, then K1 or padded-and-K2
  function automatic logic [127:0] msg_word(input logic [127:0] d, input logic last,
                                            input logic [4:0] len, input logic [127:0] sk1,
                                            input logic [127:0] sk2);
    logic [4:0] l;
    logic [7:0] sh;
    if (!last) return d;
    l  = (len > 5'd16) ? 5'd16 : len;
    sh = {l, 3'b000};
    if (l == 5'd16) return d ^ sk1;
    return ((d & ~({128{1'b1}} >> sh)) | (128'd1 << (8'd127 - sh))) ^ sk2;
  endfunction

  aes128_core u_aes (
    .clk   (clk),
    .rst_b (~rst),
    .ld    (aes_ld),
    .key   (key_r),
    .din   (aes_din),
    .dout  (aes_dout),
    .done  (aes_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    key_ready = 1'b0;
    blk_ready = 1'b0;
    tag_valid = 1'b0;
    busy      = 1'b1;
    key_go    = 1'b0;
    blk_go    = 1'b0;
    skid_go   = 1'b0;
    skid_load = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_valid) begin
          key_go   = 1'b1;
          state_nx = SUBKEY;
        end
      end
      SUBKEY: if (aes_done) state_nx = WAIT_BLK;
      WAIT_BLK: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        blk_ready = key_loaded && !key_valid;
        if (key_valid) begin
          key_go   = 1'b1;
          state_nx = SUBKEY;
        end else if (blk_valid && blk_ready) begin
          blk_go   = 1'b1;
          state_nx = blk_last ? LAST : RUN;
        end
      end
      RUN: begin
        // skid refuses on the done cycle so a block never arrives as the chain hands off
        blk_ready = (BLK_FIFO != 0) && !skid_vld && !aes_done;
        skid_load = blk_valid && blk_ready;
        if (aes_done) begin
          if (skid_vld) begin
            skid_go  = 1'b1;
            state_nx = skid_last ? LAST : RUN;
          end else begin
            state_nx = WAIT_BLK;
          end
        end
      end
      LAST: if (aes_done) state_nx = TAG_OUT;
      TAG_OUT: begin
        tag_valid = 1'b1;
        if (tag_ready) state_nx = WAIT_BLK;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r <= '0; k1 <= '0; k2 <= '0; x <= '0; aes_din <= '0; aes_ld <= 1'b0;
      key_loaded <= 1'b0; tag <= '0;
      skid_vld <= 1'b0; skid_data <= '0; skid_last <= 1'b0; skid_len <= '0;
    end else begin
      aes_ld <= 1'b0;
      if (key_go) begin
        key_r      <= key;
        aes_din    <= '0;
        aes_ld     <= 1'b1;
        key_loaded <= 1'b0;
        x          <= '0;
        skid_vld   <= 1'b0;
      end
      if (state == SUBKEY && aes_done) begin
        k1         <= dbl(aes_dout);
        k2         <= dbl(dbl(aes_dout));
        x          <= '0;
        key_loaded <= 1'b1;
      end
      if (blk_go) begin
        aes_din <= x ^ msg_word(blk_data, blk_last, blk_len, k1, k2);
        aes_ld  <= 1'b1;
      end
      if (skid_load) begin
        skid_vld  <= 1'b1;
        skid_data <= blk_data;
        skid_last <= blk_last;
        skid_len  <= blk_len;
      end
      if (state == RUN && aes_done) begin
        x <= aes_dout;
        if (skid_go) begin
          aes_din  <= aes_dout ^ msg_word(skid_data, skid_last, skid_len, k1, k2);
          aes_ld   <= 1'b1;
          skid_vld <= 1'b0;
        end
      end
      if (state == LAST && aes_done) begin
        tag <= aes_dout[127 -: TAG_BITS];
        x   <= '0;
      end
    end
  end

`ifdef CMAC_VERIFY_EN
  logic [TAG_BITS-1:0] ref_r, skid_ref;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_r <= '0; skid_ref <= '0; tag_match <= 1'b0;
    end else begin
      if (skid_load) skid_ref <= ref_tag;
      if (blk_go && blk_last)        ref_r <= ref_tag;
      else if (skid_go && skid_last) ref_r <= skid_ref;
      if (state == LAST && aes_done) tag_match <= (aes_dout[127 -: TAG_BITS] == ref_r);
    end
  end
`endif
endmodule

// File: tb/tb_cmac_engine.sv
module tb_cmac_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, blk_valid, blk_last, tag_ready;
  logic [127:0] key, blk_data;
  logic [4:0]   blk_len;
  logic         key_ready, blk_ready, tag_valid, busy;
  logic [127:0] tag;
  logic         key_ready64, blk_ready64, tag_valid64, busy64;
  logic [63:0]  tag64;
`ifdef CMAC_VERIFY_EN
  logic [127:0] ref_tag;
  logic [63:0]  ref_tag64;
  logic         tag_match, tag_match64;
`endif

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] M0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] M1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] M2  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] M3  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] M2P = 128'h30c81c46a35ce411_0123456789abcdef;
  localparam logic [127:0] T_EMPTY = 128'hbb1d6929e95937287fa37d129b756746;
  localparam logic [127:0] T_16    = 128'h070a16b46b4d4144f79bdd9dd04a287c;
  localparam logic [127:0] T_40    = 128'hdfa66747de9ae63030ca32611497c827;
  localparam logic [127:0] T_64    = 128'h51f0bebf7e3b9d92fc49741779363cfe;

  always #5 clk = ~clk;

  cmac_engine dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key(key), .key_ready(key_ready),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_len(blk_len),
    .blk_ready(blk_ready),
    .tag_valid(tag_valid), .tag(tag), .tag_ready(tag_ready),
    .busy(busy)
`ifdef CMAC_VERIFY_EN
    , .ref_tag(ref_tag), .tag_match(tag_match)
`endif
  );

  cmac_engine #(.TAG_BITS(64)) dut64 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key(key), .key_ready(key_ready64),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_len(blk_len),
    .blk_ready(blk_ready64),
    .tag_valid(tag_valid64), .tag(tag64), .tag_ready(tag_ready),
    .busy(busy64)
`ifdef CMAC_VERIFY_EN
    , .ref_tag(ref_tag64), .tag_match(tag_match64)
`endif
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key       = k;
    for (int i = 0; i < 200 && !key_ready; i++) @(negedge clk);
    check("key_ready_wait", key_ready, 1'b1);
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic send_blk(input logic [127:0] d, input logic last, input logic [4:0] len);
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    blk_len   = len;
    for (int i = 0; i < 200 && !blk_ready; i++) @(negedge clk);
    check("blk_ready_wait", blk_ready, 1'b1);
    @(posedge clk);
    #1;
    check("blk_to_ld", dut.aes_ld, 1'b1);
    blk_valid = 1'b0;
  endtask

  task automatic wait_tag(input string name, input logic [127:0] exp, input int hold);
    logic [63:0] exp64;
    exp64 = exp[127:64];
    @(negedge clk);
    for (int i = 0; i < 200 && !dut.aes_done; i++) @(negedge clk);
    check({name, "_done_wait"}, dut.aes_done, 1'b1);
    @(negedge clk);
    check({name, "_done_to_valid"}, tag_valid, 1'b1);
    check({name, "_tag"}, tag, exp);
    check({name, "_tag64"}, {tag_valid64, tag64}, {1'b1, exp64});
`ifdef CMAC_VERIFY_EN
    check({name, "_match"}, tag_match, 1'b0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold"}, {tag_valid, tag}, {1'b1, exp});
    end
    tag_ready = 1'b1;
    @(posedge clk);
    #1 tag_ready = 1'b0;
    @(negedge clk);
    check({name, "_released"}, {tag_valid, busy}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; tag_ready = 1'b0;
    key = '0; blk_data = '0; blk_len = '0;
`ifdef CMAC_VERIFY_EN
    ref_tag = '0; ref_tag64 = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_outputs", {blk_ready, tag_valid, busy}, 3'b000);
    check("rst_tag", tag, 128'h0);
    check("rst_subkeys", {dut.k1, dut.k2}, 256'h0);
    rst = 1'b0;

    // no block may be taken before a key has been expanded
    @(negedge clk);
    blk_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("no_key_blk_ready", blk_ready, 1'b0);
    blk_valid = 1'b0;

    send_key(K0);
    @(negedge clk);
    check("subkey_busy_nrdy", {busy, blk_ready}, 2'b10);
    wait_idle();
    check("k1", dut.k1, 128'hfbeed618357133667c85e08f7236a8de);
    check("k2", dut.k2, 128'hf7ddac306ae266ccf90bc11ee46d513b);

    send_blk(128'hdeadbeef_00000000_11111111_22222222, 1'b1, 5'd0);
    wait_tag("empty", T_EMPTY, 0);

    send_blk(M0, 1'b1, 5'd16);
    wait_tag("one_blk", T_16, 0);

    send_blk(M0, 1'b1, 5'd31);
    wait_tag("len_clamp", T_16, 0);

    send_blk(M0, 1'b0, 5'd3);
    send_blk(M1, 1'b0, 5'd0);
    send_blk(M2P, 1'b1, 5'd8);
    wait_tag("msg40", T_40, 5);

    send_blk(M0, 1'b0, 5'd0);
    send_blk(M1, 1'b0, 5'd0);
    send_blk(M2, 1'b0, 5'd0);
    send_blk(M3, 1'b1, 5'd16);
    wait_tag("msg64", T_64, 0);

    // reset while block 2 is in the AES core
    send_blk(M0, 1'b0, 5'd0);
    send_blk(M1, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", {key_ready, blk_ready, tag_valid, busy}, 4'b1000);
    check("midrst_state", {dut.k1, dut.x}, 256'h0);
    rst = 1'b0;
    blk_valid = 1'b1;
    blk_data  = M2;
    repeat (2) @(negedge clk);
    check("midrst_blk_nrdy", blk_ready, 1'b0);
    send_key(K0);
    @(negedge clk);
    check("midrst_subkey_nrdy", {busy, blk_ready}, 2'b10);
    blk_valid = 1'b0;
    wait_idle();
    send_blk(M0, 1'b0, 5'd0);
    send_blk(M1, 1'b0, 5'd0);
    send_blk(M2, 1'b0, 5'd0);
    send_blk(M3, 1'b1, 5'd16);
    wait_tag("resend64", T_64, 0);

    // key and block offered together: key wins, block is refused that cycle
    @(negedge clk);
    key_valid = 1'b1;
    key       = K0;
    blk_valid = 1'b1;
    blk_data  = M0;
    #1;
    check("key_wins", {key_ready, blk_ready}, 2'b10);
    @(posedge clk);
    #1 key_valid = 1'b0;
    blk_valid = 1'b0;
    wait_idle();
    check("rekey_k1", dut.k1, 128'hfbeed618357133667c85e08f7236a8de);
    send_blk(128'h0123456789abcdef_fedcba9876543210, 1'b1, 5'd0);
    wait_tag("rekey_empty", T_EMPTY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
